reg_dump_ctrl: RTL

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - sequential register-bank dump engine with ready/valid word output
// Optional trailing XOR checksum word enabled by defining REG_DUMP_CSUM_EN.
module reg_dump_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    output logic [ADDR_W-1:0] readReg,
    input  logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] outData,
    output logic [ADDR_W-1:0] outIndex,
    output logic              outValid,
    input  logic              outReady,
    output logic              outLast,
    output logic              busy,
    output logic              done
);

`ifdef REG_DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;
`ifdef REG_DUMP_CSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    wire w_at_last = (r_cur == r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_last      <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur   <= firstReg;
                        r_last  <= lastReg;
                        r_busy  <= 1'b1;
                        r_state <= READ;
`ifdef REG_DUMP_CSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                READ: begin
                    r_out_data  <= readData;
                    r_out_index <= r_cur;
                    r_out_valid <= 1'b1;
`ifdef REG_DUMP_CSUM_EN
                    // The checksum word carries the final outLast instead.
                    r_csum      <= r_csum ^ readData;
                    r_out_last  <= 1'b0;
`else
                    r_out_last  <= w_at_last;
`endif
                    r_state     <= SEND;
                end
                SEND: begin
                    if (outReady) begin
                        if (!w_at_last) begin
                            r_cur       <= r_cur + ADDR_W'(1);
                            r_out_valid <= 1'b0;
                            r_state     <= READ;
                        end else begin
`ifdef REG_DUMP_CSUM_EN
                            r_out_data  <= r_csum;
                            r_out_index <= r_last;
                            r_out_last  <= 1'b1;
                            r_state     <= CSUM;
`else
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CSUM_EN
                CSUM: begin
                    if (outReady) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign readReg  = r_cur;
    assign outData  = r_out_data;
    assign outIndex = r_out_index;
    assign outValid = r_out_valid;
    assign outLast  = r_out_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
